// File: rtl/skew_feeder.sv
// Input FIFO plus per-row skew chains feeding the west edge of a systolic array.
// Row r of a popped vector appears r+2 cycles after its pop; in_ready = FIFO not full. Optional SKEW_FEEDER_CNT_EN adds vec_count.
module skew_feeder #(
   parameter int ROWS       = 2,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ROWS*DATA_WIDTH-1:0] in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_last,
   input  logic                       in_switch,
   output logic [ROWS*DATA_WIDTH-1:0] out_data,
   output logic [ROWS-1:0]            out_valid,
   output logic [ROWS-1:0]            out_switch,
   output logic                       busy,
   output logic                       done
`ifdef SKEW_FEEDER_CNT_EN
   ,
   output logic [15:0]                vec_count
`endif
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = $clog2(ROWS + 1);

   typedef struct packed {
      logic [ROWS*DATA_WIDTH-1:0] dat;
      logic                       last;
      logic                       sw;
   } entry_t;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   entry_t        mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   occ_q;
   logic          fifo_full, fifo_empty;
   logic          push, pop;
   entry_t        head, wr_entry;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            done_d, done_q;

   logic                       p_vld_q, p_sw_q;
   logic [ROWS*DATA_WIDTH-1:0] p_dat_q;

   // ---------------- input FIFO ----------------
   assign fifo_full  = (occ_q == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty = (occ_q == '0);
   assign in_ready   = ~rst & ~fifo_full;
   assign push       = in_valid & in_ready;
   assign head       = mem_q[rd_ptr_q];

   always_comb begin
      wr_entry      = '0;
      wr_entry.dat  = in_data;
      wr_entry.last = in_last;
      wr_entry.sw   = in_switch;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   occ_q <= occ_q + 1'b1;
            2'b01:   occ_q <= occ_q - 1'b1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, STREAM: begin
            if (!fifo_empty) begin
               if (head.last) begin
                  state_d = DRAIN;
                  cnt_d   = CNTW'(ROWS);
               end else begin
                  state_d = STREAM;
               end
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pop    = (state_q != DRAIN) && !fifo_empty;
      busy   = (state_q != IDLE);
      done_d = (state_q == DRAIN) && (cnt_q == '0);
   end

   assign done = done_q;

   // ---------------- pop stage and per-row skew ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_vld_q <= 1'b0;
         p_sw_q  <= 1'b0;
         p_dat_q <= '0;
      end else begin
         p_vld_q <= pop;
         p_sw_q  <= pop & head.sw;
         p_dat_q <= pop ? head.dat : '0;
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_WIDTH-1:0] dat_q [r+1];
      logic [r:0]            vld_q, sw_q;

      // Row r is r stages deeper than row 0, so bubbles keep the skew intact.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k <= r; k++) dat_q[k] <= '0;
            vld_q <= '0;
            sw_q  <= '0;
         end else begin
            dat_q[0] <= p_dat_q[r*DATA_WIDTH +: DATA_WIDTH];
            vld_q[0] <= p_vld_q;
            sw_q[0]  <= p_sw_q;
            for (int k = 1; k <= r; k++) begin
               dat_q[k] <= dat_q[k-1];
               vld_q[k] <= vld_q[k-1];
               sw_q[k]  <= sw_q[k-1];
            end
         end
      end

      assign out_data[r*DATA_WIDTH +: DATA_WIDTH] = dat_q[r];
      assign out_valid[r]                         = vld_q[r];
      assign out_switch[r]                        = sw_q[r];
   end

`ifdef SKEW_FEEDER_CNT_EN
   logic [15:0] vcnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vcnt_q <= '0;
      end else if (pop) begin
         vcnt_q <= vcnt_q + 16'd1;
      end
   end

   assign vec_count = vcnt_q;
`endif

endmodule
